// File: rtl/rect_filler.sv
// -----------------------------------------------------------------------------
// rect_filler
//   Framebuffer producer for a 112x112, 3-bit-per-pixel screen. Accepts
//   rectangle-fill commands over a valid/ready handshake. It writes one pixel
//   per cycle, row-major, at address x + y*112. A command tagged cmd_last
//   hands the frame to the downstream flasher. out_cont_signal is held high
//   until next_fin_signal is seen.
//
//   Optional feature macro: RECT_CLIP_EN
//     defined   : rectangles overflowing the screen are clipped; err tied 0
//     undefined : overflowing rectangles are dropped (no writes); err is sticky
//
// Ports
//   Clck             clock, rising edge
//   Reset            asynchronous active-low reset
//   cmd_valid/ready  command handshake
//   cmd_x/y/w/h      rectangle origin and size (7 bits each); w or h of 0 is empty
//   cmd_color        fill colour (3 bits)
//   cmd_last         hand off the frame after this rectangle
//   write_addr/data  framebuffer write port (14-bit address, 3-bit data)
//   write_en         framebuffer write strobe
//   out_cont_signal  frame ready level to the flasher
//   next_fin_signal  flasher finished the frame
//   err              sticky out-of-bounds flag
// -----------------------------------------------------------------------------
module rect_filler (
   input  logic        Clck,
   input  logic        Reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [6:0]  cmd_x,
   input  logic [6:0]  cmd_y,
   input  logic [6:0]  cmd_w,
   input  logic [6:0]  cmd_h,
   input  logic [2:0]  cmd_color,
   input  logic        cmd_last,
   output logic [13:0] write_addr,
   output logic [2:0]  write_data,
   output logic        write_en,
   output logic        out_cont_signal,
   input  logic        next_fin_signal,
   output logic        err
);

   localparam int SCR_SIZE = 112;
   localparam int ADDR_W   = 14;
   localparam int COLOR_W  = 3;
   localparam int CRD_W    = 7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILL    = 2'd1,
      ST_HANDOFF = 2'd2
   } state_e;

   state_e              state_q;
   logic                cmd_ready_q;
   logic                write_en_q;
   logic [ADDR_W-1:0]   write_addr_q;
   logic [COLOR_W-1:0]  write_data_q;
   logic                out_cont_q;
   logic [CRD_W-1:0]    w_q;
   logic [CRD_W-1:0]    h_q;
   logic [CRD_W-1:0]    col_q;
   logic [CRD_W-1:0]    row_q;
   logic                last_q;

   // 8-bit extents so x+w cannot wrap back into range
   logic [CRD_W:0]      sum_x_s;
   logic [CRD_W:0]      sum_y_s;
   logic [CRD_W-1:0]    w_eff_d;
   logic [CRD_W-1:0]    h_eff_d;
   logic                empty_d;
   logic [ADDR_W-1:0]   start_addr_d;
   logic                accept_s;
`ifndef RECT_CLIP_EN
   logic                oob_s;
   logic                err_q;
`endif

   assign accept_s = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;

   // Effective rectangle size and start address of the incoming command
   always_comb begin
      sum_x_s = {1'b0, cmd_x} + {1'b0, cmd_w};
      sum_y_s = {1'b0, cmd_y} + {1'b0, cmd_h};
`ifdef RECT_CLIP_EN
      if ((cmd_x >= 7'd112) || (cmd_y >= 7'd112)) begin
         w_eff_d = 7'd0;
         h_eff_d = 7'd0;
      end else begin
         w_eff_d = (sum_x_s > 8'd112) ? (7'd112 - cmd_x) : cmd_w;
         h_eff_d = (sum_y_s > 8'd112) ? (7'd112 - cmd_y) : cmd_h;
      end
`else
      oob_s = (sum_x_s > 8'd112) || (sum_y_s > 8'd112);
      if (oob_s) begin
         w_eff_d = 7'd0;
         h_eff_d = 7'd0;
      end else begin
         w_eff_d = cmd_w;
         h_eff_d = cmd_h;
      end
`endif
      empty_d      = (w_eff_d == 7'd0) || (h_eff_d == 7'd0);
      // The only multiply: start address of the rectangle
      start_addr_d = ADDR_W'(cmd_x) + (ADDR_W'(cmd_y) * 14'd112);
   end

   // Control FSM with registered handshake and framebuffer outputs
   always_ff @(posedge Clck or negedge Reset) begin
      if (!Reset) begin
         state_q      <= ST_IDLE;
         cmd_ready_q  <= 1'b0;
         write_en_q   <= 1'b0;
         write_addr_q <= 14'd0;
         write_data_q <= 3'd0;
         out_cont_q   <= 1'b0;
         w_q          <= 7'd0;
         h_q          <= 7'd0;
         col_q        <= 7'd0;
         row_q        <= 7'd0;
         last_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (accept_s) begin
                  w_q          <= w_eff_d;
                  h_q          <= h_eff_d;
                  last_q       <= cmd_last;
                  write_data_q <= cmd_color;
                  col_q        <= 7'd0;
                  row_q        <= 7'd0;
                  if (!empty_d) begin
                     state_q      <= ST_FILL;
                     cmd_ready_q  <= 1'b0;
                     write_en_q   <= 1'b1;
                     write_addr_q <= start_addr_d;
                  end else if (cmd_last) begin
                     state_q     <= ST_HANDOFF;
                     cmd_ready_q <= 1'b0;
                     out_cont_q  <= 1'b1;
                  end
               end
            end
            ST_FILL: begin
               if (col_q == (w_q - 7'd1)) begin
                  if (row_q == (h_q - 7'd1)) begin
                     write_en_q <= 1'b0;
                     if (last_q) begin
                        state_q    <= ST_HANDOFF;
                        out_cont_q <= 1'b1;
                     end else begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                     end
                  end else begin
                     // Row wrap: jump from the row end to the start x of the next row
                     col_q        <= 7'd0;
                     row_q        <= row_q + 7'd1;
                     write_addr_q <= write_addr_q + 14'd112 - ADDR_W'(w_q) + 14'd1;
                  end
               end else begin
                  col_q        <= col_q + 7'd1;
                  write_addr_q <= write_addr_q + 14'd1;
               end
            end
            ST_HANDOFF: begin
               if (next_fin_signal) begin
                  state_q     <= ST_IDLE;
                  out_cont_q  <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               cmd_ready_q <= 1'b0;
               write_en_q  <= 1'b0;
               out_cont_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef RECT_CLIP_EN
   assign err = 1'b0;
`else
   // Sticky flag: any accepted command that does not fit on screen
   always_ff @(posedge Clck or negedge Reset) begin
      if (!Reset) begin
         err_q <= 1'b0;
      end else if (accept_s && oob_s) begin
         err_q <= 1'b1;
      end
   end
   assign err = err_q;
`endif

   assign cmd_ready       = cmd_ready_q;
   assign write_en        = write_en_q;
   assign write_addr      = write_addr_q;
   assign write_data      = write_data_q;
   assign out_cont_signal = out_cont_q;

endmodule

// File: doc/rect_filler.md
# rect_filler

Framebuffer producer stage placed directly upstream of the screen flasher. Accepts rectangle-fill commands over a valid/ready handshake and writes one 3-bit pixel per cycle into the 112x112 framebuffer RAM at address x + y*112. On a command tagged as end-of-frame, it hands the finished frame to the flasher through the continuation handshake. It then accepts no further commands until the flasher reports completion.

## Interface
- SCR_SIZE, 112, framebuffer width and height in pixels
- ADDR_W, 14, framebuffer address width
- COLOR_W, 3, pixel colour width
- Clck  in  1  the clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_x, cmd_y  in  7 each  top-left corner of the rectangle
- cmd_w, cmd_h  in  7 each  width and height in pixels; 0 means empty
- cmd_color  in  3  fill colour
- cmd_last  in  1  hand off the frame after this rectangle is filled
- write_addr  out  14  framebuffer write address
- write_data  out  3  framebuffer write data
- write_en  out  1  framebuffer write strobe, one pixel per cycle
- out_cont_signal  out  1  frame ready; drives the flasher's in_cont_signal
- next_fin_signal  in  1  flasher finished scanning the frame
- err  out  1  sticky out-of-bounds flag; tied 0 when clipping is compiled in

## Operation
- Reset values: cmd_ready=0, write_en=0, write_addr=0, write_data=0, out_cont_signal=0, err=0; FSM enters IDLE.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, the block latches x, y, effective w/h, colour and last.
  - Non-empty rectangle: go to FILL.
  - Empty rectangle with last=1: go to HANDOFF.
  - Empty rectangle with last=0: stay in IDLE.
- FILL
  - cmd_ready=0; write_en=1 every cycle.
  - Pixel order is row-major: x increments first, and wraps to the start x with y+1 at the row end.
  - write_addr is maintained incrementally: +1 within a row, +(SCR_SIZE - w + 1) at a row wrap. No multiplier; the only multiply is the start address x + y*SCR_SIZE, computed at accept.
  - After the last pixel: go to HANDOFF if last=1, otherwise go to IDLE.
- HANDOFF
  - cmd_ready=0; out_cont_signal=1, held as a level.
  - When next_fin_signal is sampled high: out_cont_signal=0 on the following cycle, and the FSM returns to IDLE.
  - next_fin_signal is ignored in IDLE and FILL.
- Arithmetic: bound checks use 8-bit sums (x+w, y+h) so a carry cannot wrap. The maximum address is 12543, which fits in 14 bits.
- Reset asserted mid-FILL or mid-HANDOFF abandons the partial work at once. The FSM goes to IDLE, and out_cont_signal drops asynchronously.

## Timing
- Accept in cycle T: the first write_en is at T+1.
- Last write is at T+w*h; cmd_ready is high again at T+w*h+1 when last=0.
- With last=1: out_cont_signal rises at T+w*h+1. An empty rectangle with last=1 raises it at T+1.
- Empty rectangle with last=0: cmd_ready stays high, giving back-to-back accepts every cycle.
- Throughput: exactly 1 pixel per cycle, with no bubbles within a rectangle. There is one IDLE cycle between rectangles.
- next_fin_signal high at edge E: out_cont_signal=0 and cmd_ready=1 after E+1.

## Configuration
- RECT_CLIP_EN defined:
  - A rectangle extending past column or row 111 is clipped: w_eff = SCR_SIZE - x and h_eff = SCR_SIZE - y, only when the extent overflows.
  - x >= 112 or y >= 112 gives an empty rectangle.
  - err is constant 0.
- RECT_CLIP_EN undefined:
  - Any command with x+w > 112 or y+h > 112 is accepted but treated as empty (no writes).
  - err is set to 1 and holds until Reset.
  - cmd_last is still honoured.

## Test plan
- Basic fill: cmd x=2, y=3, w=3, h=2, colour=5, last=0 -> six writes on consecutive cycles to addresses 338, 339, 340, 450, 451, 452, all with data 5; cmd_ready returns 1 at T+7.
- Handoff: cmd x=0, y=0, w=1, h=1, last=1 -> one write to address 0, then out_cont_signal=1 until next_fin_signal pulses; cmd_ready is held 0 throughout; cmd_valid during HANDOFF is not accepted.
- Boundary: cmd x=110, y=111, w=5, h=4
  - with RECT_CLIP_EN: writes to addresses 12542 and 12543 only, err=0;
  - without RECT_CLIP_EN: no writes, err=1 after accept.
- Empty rectangles: w=0 commands on 3 consecutive cycles -> 3 accepts, no write_en; w=0 with last=1 -> out_cont_signal=1 at T+1.
- Full screen: x=0, y=0, w=112, h=112 -> 12544 writes with addresses 0..12543 strictly sequential, with no gaps.
- Reset mid-FILL: assert Reset after 4 writes of an 8-pixel rectangle -> write_en=0 immediately, no further writes, cmd_ready=1 on the first cycle after release.
